shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift/rotate sequencer for the data-manipulation unit: accepts a word, an operation and a shift amount, then applies one single-bit shift or rotate per clock until the amount is exhausted. It sits directly upstream of the flag-control register. Its registered result and zero, carry and overflow flags are presented for one cycle with `done`, ready to be latched as the flag inputs of the next stage.

## Interface
- `WORD_SIZE`, 8, data width in bits.
- `AMT_W`, `$clog2(WORD_SIZE)+1`, width of the shift-amount input.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `op` in 3: operation code, as defined under Operation.
- `amount` in `AMT_W`: number of single-bit steps.
- `data_in` in `WORD_SIZE`: operand; captured with `start`.
- `busy` out 1: high while an operation is in flight (RUN).
- `done` out 1: one-cycle completion strobe.
- `data_out` out `WORD_SIZE`: result; held until the next accepted `start`.
- `zero_flag_out` out 1: `data_out == 0` at completion.
- `carry_flag_out` out 1: last bit shifted or rotated out.
- `overflow_flag_out` out 1: sticky sign-change indicator (SHL only).

## Operation
- Op codes: 000 SHL, 001 SHR (logical), 010 ROL, 011 ROR, 100 ASR (see Configuration); 101–111 are reserved.
- States: IDLE, RUN and DONE.
- **IDLE:**
  - If `start` is high, capture `data_in`, `op` and `amount` into working registers, clear carry and overflow, and go to RUN.
  - If `amount == 0` or `op` is reserved, go straight to DONE with the result equal to `data_in`, carry 0 and overflow 0.
- **RUN:**
  - Each cycle, apply one step to the working word and decrement the counter.
  - Carry takes the bit leaving the word: bit `WORD_SIZE-1` for SHL/ROL, bit 0 for SHR/ROR/ASR.
  - Rotates feed that bit back in at the opposite end.
  - SHL sets overflow if the MSB changes on any step; overflow stays sticky for the rest of the operation.
  - Go to DONE when the counter reaches 0 after the step.
- **DONE:**
  - Drive `done` high for exactly one cycle.
  - Register `zero_flag_out` from the final word.
  - Return to IDLE.
- `data_out` and the three flags update only on entry to DONE and hold their values otherwise.
- `start` in RUN or DONE is ignored; there is no queueing.
- Amounts larger than `WORD_SIZE` still iterate exactly `amount` steps. Shifts therefore saturate to all-zero (or all-sign for ASR); rotates wrap modulo `WORD_SIZE`.
- When `reset` is asserted, the block enters IDLE immediately, even mid-RUN.

## Timing
- Reset values:
  - state IDLE
  - `busy` = 0, `done` = 0
  - `data_out` = 0
  - all flags = 0
- `start` accepted at edge k with `amount = n > 0`:
  - `busy` is high for cycles k+1 … k+n.
  - `done` and the valid outputs appear at edge k+n+1.
  - Throughput: the next `start` can be accepted at edge k+n+2.
- `amount = 0` or reserved op: `done` at edge k+1 and `busy` never rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_SEQ_ARITH_SHIFT_EN` defined: op 100 is ASR, which replicates the MSB on each right step.
- Not defined: op 100 executes as SHR (logical), with identical timing and flags.

## Structure
- Package `shift_seq_pkg`:
  - the `op_t` enum (SHL, SHR, ROL, ROR, ASR codes)
  - the `state_t` enum (IDLE, RUN, DONE)
  - a `WORD_SIZE` default constant
- Sub-module `shift_step_unit`: combinational single-bit step. It takes the word and op, and produces the next word, the bit shifted out and the MSB-changed indication.
- The top level holds the FSM, the counter and the output registers.

## Test plan
1. SHL, `data_in` 11001100, amount 1 → `data_out` 10011000, carry 1, overflow 0, zero 0, `done` at k+2. Repeat with 01000000 → 10000000, overflow 1.
2. ROR, 11001100, amount 3 → 10011001, carry 1, `busy` for 3 cycles, `done` at k+4.
3. SHR, 10101010, amount 8 → 00000000, zero 1, carry 1, `done` at k+9.
4. Amount 0, `data_in` 01010101 → `data_out` 01010101, carry 0, overflow 0, `done` at k+1, `busy` stays 0.
5. Second `start` pulse during RUN → ignored, first result unchanged. `reset` low mid-RUN → all outputs 0, state IDLE, no `done`.
6. Op 100, 10000000, amount 2 → 11100000 with `SHIFT_SEQ_ARITH_SHIFT_EN` defined, 00100000 without; carry 0 in both builds.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared op codes, FSM states and default word size for the shift sequencer
package shift_seq_pkg;
  localparam int DEFAULT_WORD_SIZE = 8;
  typedef enum logic [2:0] {
    SHL = 3'b000,
    SHR = 3'b001,
    ROL = 3'b010,
    ROR = 3'b011,
    ASR = 3'b100
  } op_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_step_unit.sv
// shift_step_unit: combinational single-bit shift/rotate step
//   word      - current working word
//   op        - operation (SHL/SHR/ROL/ROR/ASR)
//   next_word - word after one step
//   out_bit   - bit leaving the word on this step
//   msb_chg   - MSB differs between word and next_word
// Build option SHIFT_SEQ_ARITH_SHIFT_EN: op ASR replicates the MSB; otherwise it behaves as SHR.
module shift_step_unit
  import shift_seq_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] word,
  input  op_t                  op,
  output logic [WORD_SIZE-1:0] next_word,
  output logic                 out_bit,
  output logic                 msb_chg
);
  logic fill;
`ifdef SHIFT_SEQ_ARITH_SHIFT_EN
  assign fill = (op == ASR) & word[WORD_SIZE-1];
`else
  assign fill = 1'b0;
`endif
  assign next_word = (op == SHL) ? {word[WORD_SIZE-2:0], 1'b0} :
                     (op == ROL) ? {word[WORD_SIZE-2:0], word[WORD_SIZE-1]} :
                     {(op == ROR) ? word[0] : fill, word[WORD_SIZE-1:1]};
  assign out_bit = (op == SHL || op == ROL) ? word[WORD_SIZE-1] : word[0];
  assign msb_chg = next_word[WORD_SIZE-1] ^ word[WORD_SIZE-1];
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate sequencer, one single-bit step per clock
//   clk, reset (async, active-low)
//   start, op, amount, data_in - request, captured in IDLE
//   busy  - operation in flight
//   done  - one-cycle completion strobe
//   data_out, zero/carry/overflow_flag_out - registered result, held until next completion
// Build option SHIFT_SEQ_ARITH_SHIFT_EN: op 100 is arithmetic right shift, else logical.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int AMT_W     = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [AMT_W-1:0]     amount,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 zero_flag_out,
  output logic                 carry_flag_out,
  output logic                 overflow_flag_out
);
  state_t               state;
  logic [WORD_SIZE-1:0] work, next_word;
  logic [2:0]           op_q;
  logic [AMT_W-1:0]     cnt;
  logic                 ovf, out_bit, msb_chg, ovf_next;
  shift_step_unit #(.WORD_SIZE(WORD_SIZE)) u_step (
    .word     (work),
    .op       (op_t'(op_q)),
    .next_word(next_word),
    .out_bit  (out_bit),
    .msb_chg  (msb_chg)
  );
  // overflow only accumulates for left shifts and is sticky across steps
  assign ovf_next = ovf | ((op_q == SHL) & msb_chg);
  assign busy     = state == RUN;
  assign done     = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      work              <= '0;
      op_q              <= '0;
      cnt               <= '0;
      ovf               <= 1'b0;
      data_out          <= '0;
      zero_flag_out     <= 1'b0;
      carry_flag_out    <= 1'b0;
      overflow_flag_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          work <= data_in;
          op_q <= op;
          cnt  <= amount;
          ovf  <= 1'b0;
          // nothing to iterate: complete at once with the operand unchanged
          if (amount == '0 || op > ASR) begin
            state             <= DONE;
            data_out          <= data_in;
            zero_flag_out     <= data_in == '0;
            carry_flag_out    <= 1'b0;
            overflow_flag_out <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          work <= next_word;
          cnt  <= cnt - AMT_W'(1);
          ovf  <= ovf_next;
          if (cnt == AMT_W'(1)) begin
            state             <= DONE;
            data_out          <= next_word;
            zero_flag_out     <= next_word == '0;
            carry_flag_out    <= out_bit;
            overflow_flag_out <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed table-driven bench for shift_sequencer
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] amount = '0;
  logic [7:0] data_in = '0;
  logic       busy, done, zero_flag_out, carry_flag_out, overflow_flag_out;
  logic [7:0] data_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;
  vec_t vecs[12];
  shift_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .amount           (amount),
    .data_in          (data_in),
    .busy             (busy),
    .done             (done),
    .data_out         (data_out),
    .zero_flag_out    (zero_flag_out),
    .carry_flag_out   (carry_flag_out),
    .overflow_flag_out(overflow_flag_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int lat, busy_n, exp_lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_lat = (v.amt == 0 || v.op > 3'd4) ? 0 : int'(v.amt);
    op = v.op;
    amount = v.amt;
    data_in = v.din;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat);
    check({tag, "_data_out"}, int'(data_out), int'(v.dout));
    check({tag, "_carry"}, int'(carry_flag_out), int'(v.c));
    check({tag, "_overflow"}, int'(overflow_flag_out), int'(v.o));
    check({tag, "_zero"}, int'(zero_flag_out), int'(v.z));
    tick();
    check({tag, "_done_one_cycle"}, int'(done), 0);
    check({tag, "_data_held"}, int'(data_out), int'(v.dout));
  endtask
  initial begin
    int lat;
    bit seen;
    vecs[0]  = '{3'b000, 4'd1,  8'b11001100, 8'b10011000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 4'd1,  8'b01000000, 8'b10000000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b011, 4'd3,  8'b11001100, 8'b10011001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 4'd8,  8'b10101010, 8'b00000000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'b000, 4'd0,  8'b01010101, 8'b01010101, 1'b0, 1'b0, 1'b0};
`ifdef SHIFT_SEQ_ARITH_SHIFT_EN
    vecs[5]  = '{3'b100, 4'd2,  8'b10000000, 8'b11100000, 1'b0, 1'b0, 1'b0};
`else
    vecs[5]  = '{3'b100, 4'd2,  8'b10000000, 8'b00100000, 1'b0, 1'b0, 1'b0};
`endif
    vecs[6]  = '{3'b010, 4'd1,  8'b10000001, 8'b00000011, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 4'd3,  8'h5A,       8'h5A,       1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 4'd9,  8'b10110100, 8'b01101001, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 4'd15, 8'h81,       8'h00,       1'b0, 1'b1, 1'b1};
    vecs[10] = '{3'b001, 4'd1,  8'h01,       8'h00,       1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b111, 4'd0,  8'h00,       8'h00,       1'b0, 1'b0, 1'b1};
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_flags", int'({zero_flag_out, carry_flag_out, overflow_flag_out}), 0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    // start pulse while RUN must be ignored
    op = 3'b000;
    amount = 4'd4;
    data_in = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 3'b011;
    amount = 4'd1;
    data_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_latency", lat, 4);
    check("ign_data_out", int'(data_out), 8'h10);
    check("ign_carry", int'(carry_flag_out), 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("ign_no_second_op", int'(seen), 0);
    // reset mid-RUN after a result with carry and overflow set
    run_vec(12, '{3'b000, 4'd1, 8'b11000000, 8'b10000000, 1'b1, 1'b0, 1'b0});
    run_vec(13, '{3'b000, 4'd2, 8'b01100000, 8'b10000000, 1'b1, 1'b1, 1'b0});
    op = 3'b000;
    amount = 4'd5;
    data_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy_before_reset", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_data_out", int'(data_out), 0);
    check("mid_rst_flags", int'({zero_flag_out, carry_flag_out, overflow_flag_out}), 0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_no_done", int'(seen), 0);
    run_vec(14, vecs[2]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
